// File: rtl/zcu_clk_pkg.sv
// Shared types and helpers for the clock-infrastructure supervisors.
package zcu_clk_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT,
    WAIT_LOCK,
    SETTLE,
    IDLE,
    PS_ISSUE,
    PS_WAIT,
    FAULT
  } sup_state_t;

  localparam int unsigned STAT_W = 8;

  // Bits needed for a counter that runs 0 .. max_val-1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/clk_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level.
module clk_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmcm_phase_supervisor.sv
// MMCM reset sequencing, lock qualification with retry/fault, and
// dynamic fine phase-shift walking toward a signed target.
module mmcm_phase_supervisor
  import zcu_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned PS_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mmcm_locked,
  output logic                   mmcm_rst,
  output logic                   ps_en,
  output logic                   ps_incdec,
  input  logic                   ps_done,
  input  logic                   ps_req,
  input  logic signed [PS_W-1:0] ps_target,
  output logic signed [PS_W-1:0] ps_current,
  output logic                   ready,
  output logic                   phase_ok,
  output logic                   fault,
  output logic [STAT_W-1:0]      retry_cnt,
  output logic [STAT_W-1:0]      lock_lost_cnt
);

  localparam int unsigned CNT_W = cnt_width(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));

  sup_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [PS_W-1:0]  target_q, target_d;
  logic signed [PS_W-1:0]  cur_d;
  logic                    dir_d;
  logic [STAT_W-1:0]       retry_d, lost_d;
  logic                    lock_loss;
  logic                    ready_d;
  logic                    locked_s;

  clk_sync_bit u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (mmcm_locked),
    .q   (locked_s)
  );

  // Next-state and next-value logic for the whole supervisor.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    target_d  = target_q;
    cur_d     = ps_current;
    dir_d     = ps_incdec;
    retry_d   = retry_cnt;
    lost_d    = lock_lost_cnt;
    lock_loss = 1'b0;

    if (ps_req && (state_q != FAULT)) target_d = ps_target;

    case (state_q)
      RST_ASSERT: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = sat_inc(retry_cnt);
          cnt_d   = '0;
          state_d = (retry_d == STAT_W'(MAX_RETRIES)) ? FAULT : RST_ASSERT;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = IDLE;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else if (ps_current != target_q) begin
          state_d = PS_ISSUE;
          dir_d   = (target_q > ps_current);
        end
      end
      PS_ISSUE: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
        end else begin
          state_d = PS_WAIT;
          cnt_d   = '0;
        end
      end
      PS_WAIT: begin
        // A PSDONE that never arrives is handled like a lost lock.
        if (!locked_s || (cnt_q == CNT_W'(LOCK_TIMEOUT - 1))) begin
          lock_loss = 1'b1;
        end else if (ps_done) begin
          cur_d   = ps_incdec ? ps_current + PS_W'(1) : ps_current - PS_W'(1);
          state_d = IDLE;
        end
      end
      FAULT: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = RST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    if (lock_loss) begin
      lost_d  = sat_inc(lock_lost_cnt);
      state_d = RST_ASSERT;
      cnt_d   = '0;
    end

    // The MMCM drops any applied phase offset while held in reset.
    if (state_d == RST_ASSERT) cur_d = '0;

    ready_d = (state_d == IDLE) || (state_d == PS_ISSUE) || (state_d == PS_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_ASSERT;
      cnt_q         <= '0;
      target_q      <= '0;
      ps_current    <= '0;
      ps_incdec     <= 1'b0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
      mmcm_rst      <= 1'b1;
      ps_en         <= 1'b0;
      ready         <= 1'b0;
      phase_ok      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      ps_current    <= cur_d;
      ps_incdec     <= dir_d;
      retry_cnt     <= retry_d;
      lock_lost_cnt <= lost_d;
      mmcm_rst      <= (state_d == RST_ASSERT) || (state_d == FAULT);
      ps_en         <= (state_d == PS_ISSUE);
      ready         <= ready_d;
      phase_ok      <= ready_d && (cur_d == target_d);
      fault         <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_mmcm_phase_supervisor.sv
// Directed bench for mmcm_phase_supervisor with an MMCM lock model and PSDONE responder.
module tb_mmcm_phase_supervisor;

  localparam int unsigned PS_W     = 16;
  localparam int          DONE_DLY = 12;
  localparam int          LOCK_DLY = 100;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mmcm_locked;
  logic                   mmcm_rst;
  logic                   ps_en;
  logic                   ps_incdec;
  logic                   ps_done;
  logic                   ps_req;
  logic signed [PS_W-1:0] ps_target;
  logic signed [PS_W-1:0] ps_current;
  logic                   ready;
  logic                   phase_ok;
  logic                   fault;
  logic [7:0]             retry_cnt;
  logic [7:0]             lock_lost_cnt;

  bit lock_en;
  bit force_low;
  int n_en, n_inc, n_dec;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [PS_W-1:0] target;
    int                     exp_inc;
    int                     exp_dec;
  } ps_vec_t;

  ps_vec_t vecs[5];

  mmcm_phase_supervisor #(
    .RST_CYCLES    (16),
    .LOCK_TIMEOUT  (200),
    .SETTLE_CYCLES (64),
    .MAX_RETRIES   (3),
    .PS_W          (PS_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mmcm_locked   (mmcm_locked),
    .mmcm_rst      (mmcm_rst),
    .ps_en         (ps_en),
    .ps_incdec     (ps_incdec),
    .ps_done       (ps_done),
    .ps_req        (ps_req),
    .ps_target     (ps_target),
    .ps_current    (ps_current),
    .ready         (ready),
    .phase_ok      (phase_ok),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk = ~clk;

  // MMCM lock model: locks LOCK_DLY cycles after mmcm_rst falls.
  initial begin
    int since;
    since = 0;
    mmcm_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (mmcm_rst) since = 0;
      else if (since < 100000) since++;
      mmcm_locked = lock_en && (since >= LOCK_DLY) && !force_low;
    end
  end

  // PSDONE responder and PSEN monitor.
  initial begin
    int pend;
    pend = 0;
    n_en = 0; n_inc = 0; n_dec = 0;
    ps_done = 1'b0;
    forever begin
      @(negedge clk);
      ps_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) ps_done = 1'b1;
      end
      if (ps_en) begin
        pend = DONE_DLY;
        n_en++;
        if (ps_incdec) n_inc++;
        else n_dec++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int n, falls, b_inc, b_dec, b_en;
    bit prev;

    vecs[0] = '{target: 16'sd5,  exp_inc: 5, exp_dec: 0};
    vecs[1] = '{target: -16'sd3, exp_inc: 0, exp_dec: 8};
    vecs[2] = '{target: -16'sd3, exp_inc: 0, exp_dec: 0};
    vecs[3] = '{target: -16'sd1, exp_inc: 2, exp_dec: 0};
    vecs[4] = '{target: 16'sd0,  exp_inc: 1, exp_dec: 0};

    rst = 1'b1; ps_req = 1'b0; ps_target = '0; lock_en = 1'b1; force_low = 1'b0;
    tick(3);
    chk("rst_mmcm_rst", int'(mmcm_rst), 1);
    chk("rst_ps_en", int'(ps_en), 0);
    chk("rst_ps_incdec", int'(ps_incdec), 0);
    chk("rst_ps_current", int'(ps_current), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_phase_ok", int'(phase_ok), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_retry_cnt", int'(retry_cnt), 0);
    chk("rst_lock_lost_cnt", int'(lock_lost_cnt), 0);

    // Reset pulse width after reset release.
    rst = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (mmcm_rst && n < 100);
    chk("mmcm_rst_pulse_len", n, 16);

    // Lock latency: locked rise to ready.
    n = 0;
    while (!mmcm_locked && n < 400) begin tick(1); n++; end
    chk("lock_seen", int'(mmcm_locked), 1);
    n = 1;
    while (!ready && n < 300) begin tick(1); n++; end
    chk("lock_to_ready_cycles", n, 2 + 1 + 64);
    chk("retry_after_lock", int'(retry_cnt), 0);
    chk("phase_ok_at_zero", int'(phase_ok), 1);

    // Table of phase targets walked with PSDONE DONE_DLY cycles after PSEN.
    for (int i = 0; i < 5; i++) begin
      b_inc = n_inc; b_dec = n_dec;
      ps_target = vecs[i].target; ps_req = 1'b1;
      tick(1);
      ps_req = 1'b0;
      tick(1);
      if (vecs[i].exp_inc + vecs[i].exp_dec != 0)
        chk($sformatf("v%0d_phase_ok_drop", i), int'(phase_ok), 0);
      n = 0;
      while (!(phase_ok && ps_current == vecs[i].target) && n < 500) begin tick(1); n++; end
      tick(20);
      chk($sformatf("v%0d_ps_current", i), int'(ps_current), int'(vecs[i].target));
      chk($sformatf("v%0d_phase_ok", i), int'(phase_ok), 1);
      chk($sformatf("v%0d_inc_pulses", i), n_inc - b_inc, vecs[i].exp_inc);
      chk($sformatf("v%0d_dec_pulses", i), n_dec - b_dec, vecs[i].exp_dec);
    end

    // Lock drop in PS_WAIT at ps_current=2, target 4; phase re-walked after relock.
    ps_target = 16'sd4; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    n = 0;
    while (ps_current != 16'sd2 && n < 500) begin tick(1); n++; end
    n = 0;
    while (!ps_en && n < 50) begin tick(1); n++; end
    chk("drop_issue_seen", int'(ps_en), 1);
    tick(2);
    force_low = 1'b1;
    n = 0;
    while (!mmcm_rst && n < 50) begin tick(1); n++; end
    force_low = 1'b0;
    chk("drop_mmcm_rst", int'(mmcm_rst), 1);
    chk("drop_lock_lost_cnt", int'(lock_lost_cnt), 1);
    chk("drop_ps_current", int'(ps_current), 0);
    chk("drop_ready", int'(ready), 0);
    b_inc = n_inc; b_dec = n_dec;
    n = 0;
    while (!(phase_ok && ps_current == 16'sd4) && n < 1500) begin tick(1); n++; end
    tick(20);
    chk("relock_ps_current", int'(ps_current), 4);
    chk("relock_inc_pulses", n_inc - b_inc, 4);
    chk("relock_dec_pulses", n_dec - b_dec, 0);

    // One-cycle lock glitch during SETTLE restarts the settle count.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n = 0;
    while (!mmcm_locked && n < 400) begin tick(1); n++; end
    tick(29);
    chk("glitch_not_ready_yet", int'(ready), 0);
    force_low = 1'b1;
    tick(1);
    force_low = 1'b0;
    n = 1;
    while (!ready && n < 300) begin tick(1); n++; end
    chk("glitch_to_ready_cycles", n, 2 + 1 + 64);

    // Reset in the middle of a step; late PSDONE must be ignored.
    ps_target = 16'sd3; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    n = 0;
    while (!ps_en && n < 50) begin tick(1); n++; end
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_ps_current", int'(ps_current), 0);
    chk("midrst_ps_en", int'(ps_en), 0);
    chk("midrst_mmcm_rst", int'(mmcm_rst), 1);
    chk("midrst_ready", int'(ready), 0);
    rst = 1'b0;
    tick(DONE_DLY + 4);
    chk("midrst_late_done_ignored", int'(ps_current), 0);

    // Lock never arrives: three reset pulses then sticky FAULT.
    rst = 1'b1; lock_en = 1'b0;
    tick(2);
    rst = 1'b0;
    falls = 0; prev = mmcm_rst; n = 0;
    while (!fault && n < 3000) begin
      tick(1);
      n++;
      if (prev && !mmcm_rst) falls++;
      prev = mmcm_rst;
    end
    chk("fault_set", int'(fault), 1);
    chk("fault_reset_pulses", falls, 3);
    chk("fault_mmcm_rst", int'(mmcm_rst), 1);
    chk("fault_retry_cnt", int'(retry_cnt), 3);
    chk("fault_ready", int'(ready), 0);
    b_en = n_en;
    ps_target = 16'sd7; ps_req = 1'b1;
    tick(1);
    ps_req = 1'b0;
    tick(30);
    chk("fault_ps_req_no_psen", n_en - b_en, 0);
    chk("fault_ps_current", int'(ps_current), 0);
    chk("fault_sticky", int'(fault), 1);
    chk("fault_phase_ok", int'(phase_ok), 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("fault_cleared_by_rst", int'(fault), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
